// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan controller: FSM state codes and sizes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mux_scan_pkg;

  localparam int CHANNELS = 8;  // mux inputs scanned per pass
  localparam int SEL_W    = 3;  // width of the channel index {s1,s2,s3}
  localparam int CNT_W    = 4;  // settle counter width (SETTLE_CYCLES up to 15)

  // FSM state enumeration, kept as plain 2-bit codes for legacy compatibility.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Handshake and mux-facing bundle between a scan requester and the scan controller.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while the controller is idle.
//
// master: requester side (drives start/abort, supplies mux output y)
// slave : controller side (drives selects, busy/done status and captured data)
interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic                start;
  logic                abort;
  logic                y;
  logic                s1;
  logic                s2;
  logic                s3;
  logic                busy;
  logic                done;
  logic [CHANNELS-1:0] data;

  modport master (
    output start, abort, y,
    input  s1, s2, s3, busy, done, data
  );

  modport slave (
    input  start, abort, y,
    output s1, s2, s3, busy, done, data
  );

endinterface

// File: rtl/mux_8x1.sv
// Combinational 8:1 mux; {s1,s2,s3} = 0 selects x1, 7 selects x8.
// Latency: combinational.
// Backpressure: none.
//
// Ports: x1..x8 data inputs, s1 (MSB) / s2 / s3 (LSB) select, y output.
module mux_8x1 (
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic x5,
  input  logic x6,
  input  logic x7,
  input  logic x8,
  input  logic s1,
  input  logic s2,
  input  logic s3,
  output logic y
);

  always_comb begin
    y = x1;
    case ({s1, s2, s3})
      3'd0: y = x1;
      3'd1: y = x2;
      3'd2: y = x3;
      3'd3: y = x4;
      3'd4: y = x5;
      3'd5: y = x6;
      3'd6: y = x7;
      3'd7: y = x8;
      default: y = x1;
    endcase
  end

endmodule

// File: rtl/mux_scan_ctrl_settle_counter.sv
// Loadable down-counter that times how long each mux select is held.
// Latency: zero asserts combinationally from the registered count.
// Backpressure: none; load wins over counting, counting stops at zero.
//
// Ports: clk, rst_n; load (in) copies value into the count; en (in) allows
// decrementing; value (in) reload amount; zero (out) count has reached 0.
module settle_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps an 8:1 mux through all channels, samples y per channel, returns one byte.
// Latency: done/data valid 8*SETTLE_CYCLES+1 cycles after the start edge.
// Backpressure: start ignored unless idle; abort cancels a scan without done.
//
// Ports: clk, rst_n (async, active-low); bus (slave modport): start/abort in,
// y in from the mux, s1..s3 select out, busy/done status out, data[7:0] out
// where data[i] is the sample taken with select = i.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_scan_ctrl_if.slave bus
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]          state;
  logic [SEL_W-1:0]    sel;
  logic [CHANNELS-1:0] cap;
  logic [CHANNELS-1:0] data_q;
  logic                busy_q;
  logic                done_q;

  logic in_wait;
  logic sample;
  logic cnt_zero;
  logic cnt_load;

  assign in_wait  = (state == ST_WAIT);
  // abort outranks sampling: a cancelled edge never captures or advances.
  assign sample   = in_wait && !bus.abort && cnt_zero;
  // Reload on scan acceptance and on every channel step except the last.
  assign cnt_load = ((state == ST_IDLE) && bus.start) || (sample && (sel != LAST_SEL));

  settle_counter #(
    .W(CNT_W)
  ) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .en    (in_wait),
    .value (RELOAD),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      sel    <= '0;
      cap    <= '0;
      data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state  <= ST_WAIT;
            sel    <= '0;
            cap    <= '0;
            busy_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            sel    <= '0;
            busy_q <= 1'b0;
          end else if (sample) begin
            if (sel != LAST_SEL) begin
              cap[sel] <= bus.y;
              sel      <= sel + SEL_W'(1);
            end else begin
              // Last channel goes straight into data; cap only holds 0..6.
              data_q <= {bus.y, cap[CHANNELS-2:0]};
              state  <= ST_DONE;
              sel    <= '0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          sel    <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s1   = sel[2];
  assign bus.s2   = sel[1];
  assign bus.s3   = sel[0];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.data = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] xv;  // xv[i] drives mux input x(i+1)

  always #5 clk = ~clk;

  mux_scan_ctrl_if bus2 ();
  mux_scan_ctrl_if bus1 ();

  mux_8x1 mx2 (
    .x1(xv[0]), .x2(xv[1]), .x3(xv[2]), .x4(xv[3]),
    .x5(xv[4]), .x6(xv[5]), .x7(xv[6]), .x8(xv[7]),
    .s1(bus2.s1), .s2(bus2.s2), .s3(bus2.s3), .y(bus2.y)
  );
  mux_8x1 mx1 (
    .x1(xv[0]), .x2(xv[1]), .x3(xv[2]), .x4(xv[3]),
    .x5(xv[4]), .x6(xv[5]), .x7(xv[6]), .x8(xv[7]),
    .s1(bus1.s1), .s2(bus1.s2), .s3(bus1.s3), .y(bus1.y)
  );

  mux_scan_ctrl #(.SETTLE_CYCLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  mux_scan_ctrl #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_d;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] sel2();
    return {bus2.s1, bus2.s2, bus2.s3};
  endfunction

  function automatic logic [2:0] sel1();
    return {bus1.s1, bus1.s2, bus1.s3};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus2.start = 1'b0; bus2.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    xv = 8'h5A;  // x1..x8 = 0,1,0,1,1,0,1,0
    #12;
    n_chk++;
    if ({bus2.busy, bus2.done, sel2(), bus2.data} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_s2: busy=%b done=%b sel=%0d data=%h, want all 0",
               bus2.busy, bus2.done, sel2(), bus2.data);
    end
    n_chk++;
    if ({bus1.busy, bus1.done, sel1(), bus1.data} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_s1: busy=%b done=%b sel=%0d data=%h, want all 0",
               bus1.busy, bus1.done, sel1(), bus1.data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_scan();
    int busy_cnt = 0;
    int done_at  = -1;
    bus2.start = 1'b1;
    exp_q.push_back(xv);
    tick();
    bus2.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bus2.busy) busy_cnt++;
      if (bus2.done) begin
        done_at = c;
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_chk++;
        if (bus2.data !== exp_d) begin
          n_fail++;
          $display("FAIL single_data: got %h want %h", bus2.data, exp_d);
        end
        break;
      end
      tick();
    end
    n_chk++;
    if (done_at != 17) begin
      n_fail++;
      $display("FAIL single_latency: done at cycle %0d want 17 (-1 = timeout)", done_at);
    end
    n_chk++;
    if (busy_cnt != 16) begin
      n_fail++;
      $display("FAIL single_busy_len: busy %0d cycles want 16", busy_cnt);
    end
    tick();
    n_chk++;
    if (bus2.done !== 1'b0 || bus2.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after_done: done=%b busy=%b want 0 0", bus2.done, bus2.busy);
    end
  endtask

  task automatic test_select_sequence();
    int errs = 0;
    bus2.start = 1'b1;
    exp_q.push_back(xv);
    tick();
    bus2.start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (sel2() !== 3'((c - 1) / 2) || bus2.busy !== 1'b1 || bus2.done !== 1'b0) begin
        errs++;
        $display("FAIL select_step: cycle %0d sel=%0d busy=%b done=%b want sel=%0d busy=1 done=0",
                 c, sel2(), bus2.busy, bus2.done, (c - 1) / 2);
      end
      tick();
    end
    n_chk++;
    if (errs != 0) n_fail++;
    n_chk++;
    if (sel2() !== 3'd0 || bus2.done !== 1'b1 || bus2.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL select_done: sel=%0d done=%b busy=%b want 0 1 0", sel2(), bus2.done, bus2.busy);
    end
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_chk++;
    if (bus2.data !== exp_d) begin
      n_fail++;
      $display("FAIL select_data: got %h want %h", bus2.data, exp_d);
    end
    tick();
  endtask

  task automatic test_abort();
    int dones = 0;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    bus2.abort = 1'b1;
    tick();
    bus2.abort = 1'b0;
    n_chk++;
    if (bus2.busy !== 1'b0 || sel2() !== 3'd0 || bus2.data !== 8'h5A) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b sel=%0d data=%h want 0 0 5a", bus2.busy, sel2(), bus2.data);
    end
    for (int c = 0; c < 25; c++) begin
      if (bus2.done) dones++;
      tick();
    end
    n_chk++;
    if (dones != 0 || bus2.data !== 8'h5A) begin
      n_fail++;
      $display("FAIL abort_no_done: dones=%0d data=%h want 0 5a", dones, bus2.data);
    end
  endtask

  task automatic test_back_to_back();
    int d1 = -1, d2 = -1, ndone = 0;
    bus2.start = 1'b1;
    exp_q.push_back(xv);
    for (int c = 1; c <= 60 && ndone < 2; c++) begin
      tick();
      if (bus2.done) begin
        ndone++;
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_chk++;
        if (bus2.data !== exp_d) begin
          n_fail++;
          $display("FAIL b2b_data%0d: got %h want %h", ndone, bus2.data, exp_d);
        end
        if (ndone == 1) begin
          d1 = c;
          xv = 8'hFF;
          exp_q.push_back(xv);
        end else begin
          d2 = c;
          bus2.start = 1'b0;
        end
      end
    end
    n_chk++;
    if (ndone != 2 || d1 != 17 || (d2 - d1) != 18) begin
      n_fail++;
      $display("FAIL b2b_timing: dones=%0d first=%0d period=%0d want 2 17 18", ndone, d1, d2 - d1);
    end
    bus2.start = 1'b0;
    tick();
    tick();
    n_chk++;
    if (bus2.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stop: busy=%b want 0", bus2.busy);
    end
  endtask

  task automatic test_midscan_reset();
    int done_at = -1;
    xv = 8'h5A;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus2.data !== 8'h00 || bus2.busy !== 1'b0 || sel2() !== 3'd0 || bus2.done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: data=%h busy=%b sel=%0d done=%b want 00 0 0 0",
               bus2.data, bus2.busy, sel2(), bus2.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus2.start = 1'b1;
    exp_q.push_back(xv);
    tick();
    bus2.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bus2.done) begin
        done_at = c;
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_chk++;
        if (bus2.data !== exp_d) begin
          n_fail++;
          $display("FAIL post_reset_data: got %h want %h", bus2.data, exp_d);
        end
        break;
      end
      tick();
    end
    n_chk++;
    if (done_at != 17) begin
      n_fail++;
      $display("FAIL post_reset_latency: done at %0d want 17 (-1 = timeout)", done_at);
    end
    tick();
  endtask

  task automatic test_settle_one();
    int done_at = -1, busy_cnt = 0, extra = 0;
    bus1.start = 1'b1;
    exp_q.push_back(xv);
    tick();
    bus1.start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (bus1.busy) busy_cnt++;
      if (bus1.done) begin
        if (done_at < 0) begin
          done_at = c;
          exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          n_chk++;
          if (bus1.data !== exp_d) begin
            n_fail++;
            $display("FAIL s1_data: got %h want %h", bus1.data, exp_d);
          end
        end else begin
          extra++;
        end
      end
      bus1.start = (c == 3);  // mid-scan start must be ignored
      tick();
    end
    bus1.start = 1'b0;
    n_chk++;
    if (done_at != 9) begin
      n_fail++;
      $display("FAIL s1_latency: done at %0d want 9 (-1 = timeout)", done_at);
    end
    n_chk++;
    if (busy_cnt != 8 || extra != 0) begin
      n_fail++;
      $display("FAIL s1_ignore_start: busy=%0d extra_dones=%0d want 8 0", busy_cnt, extra);
    end
  endtask

  initial begin
    test_reset();
    test_single_scan();
    test_select_sequence();
    test_abort();
    test_back_to_back();
    test_midscan_reset();
    test_settle_one();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
